// File: rtl/rv_ahb_pkg.sv
// Shared AHB-Lite types and helpers for the SRAM slave: transfer/size encodings,
// little-endian byte-enable decode and active-transfer test.
package rv_ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        HS_BYTE = 2'd0,
        HS_HALF = 2'd1,
        HS_WORD = 2'd2
    } hsize_t;

    // Misaligned or illegal size/offset pairs yield no lanes, which drops the write.
    function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HS_BYTE: be = 4'b0001 << offset;
            HS_HALF: if (!offset[0]) be = offset[1] ? 4'b1100 : 4'b0011;
            HS_WORD: if (offset == 2'd0) be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic trans_active(input logic [1:0] trans);
        return (trans == HT_NONSEQ) || (trans == HT_SEQ);
    endfunction

endpackage

// File: rtl/rv_sram_1rw.sv
// Word-wide memory, one synchronous read and one byte-enabled write per cycle.
// Read data 1 cycle after re and held otherwise; no backpressure. Read-during-write returns old data.
// Reset clears only the read register, never the array.
module rv_sram_1rw #(
    parameter int AW        = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic [3:0]    we_be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);
    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0000_0000 : {32{1'bx}})};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/rv_ahb_sram_slave.sv
// AHB-Lite SRAM slave behind the two-master arbiter; pipelined address/data phases.
// Read data valid WAIT+1 cycles... i.e. from the first data-phase cycle; writes commit on the ready edge.
// Backpressure: RDYBus low for WAIT cycles of every data phase; address inputs ignored meanwhile.
module rv_ahb_sram_slave
    import rv_ahb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int WAIT      = 0,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ABus,
    input  logic [1:0]  TRANSBus,
    input  logic        WRITEBus,
    input  logic [1:0]  SIZEBus,
    input  logic [31:0] WDBus,
    output logic [31:0] RDBus,
    output logic        RDYBus
);
    localparam int         WA_W     = ADDR_W - 2;
    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    logic            dp_v;
    logic            dp_write;
    logic [WA_W-1:0] dp_addr;
    logic [1:0]      dp_off;
    logic [1:0]      dp_size;
    logic [2:0]      wcnt;
    logic [3:0]      fwd_be;
    logic [31:0]     fwd_dat;
    logic [31:0]     mem_rdata;
    logic [3:0]      commit_be;
    logic [WA_W-1:0] a_word;
    logic            rdy;
    logic            accept;
    logic            rd_issue;
    logic            unused_abus;

    assign a_word      = ABus[ADDR_W-1:2];
    assign unused_abus = ^ABus[31:ADDR_W];

    assign rdy       = !(dp_v && (wcnt != 3'd0));
    assign accept    = rdy && trans_active(TRANSBus);
    assign rd_issue  = accept && !WRITEBus;
    assign commit_be = (rdy && dp_v && dp_write) ? be_from_size(dp_size, dp_off) : 4'b0000;
    assign RDYBus    = rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_v     <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_off   <= 2'd0;
            dp_size  <= 2'd0;
            wcnt     <= 3'd0;
            fwd_be   <= 4'b0000;
            fwd_dat  <= 32'h0;
        end else if (rdy) begin
            dp_v <= accept;
            if (accept) begin
                dp_write <= WRITEBus;
                dp_addr  <= a_word;
                dp_off   <= ABus[1:0];
                dp_size  <= SIZEBus;
                wcnt     <= WAIT_CNT;
            end
            // The array returns pre-write data for a same-edge collision, so remember the lanes to patch.
            if (rd_issue) begin
                fwd_be  <= (dp_addr == a_word) ? commit_be : 4'b0000;
                fwd_dat <= WDBus;
            end
        end else begin
            wcnt <= wcnt - 3'd1;
        end
    end

    always_comb begin
        RDBus = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fwd_be[i]) RDBus[8*i +: 8] = fwd_dat[8*i +: 8];
        end
    end

    rv_sram_1rw #(
        .AW        (WA_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (rd_issue),
        .raddr (a_word),
        .rdata (mem_rdata),
        .we_be (commit_be),
        .waddr (dp_addr),
        .wdata (WDBus)
    );

endmodule
